dram_write_bridge: RTL and testbench

- Downstream stage of the sample packer, between the packer and the DDR memory controller user interface (app_* command/write-data ports).
- Accepts one MEM_IF_WIDTH write (data + address) per write_req, buffers it in a small FIFO, and drives it to the controller.
- Command handshake (app_en/app_rdy) and write-data handshake (app_wdf_wren/app_wdf_rdy) complete independently.
- Generates write_allowed back to the packer.

---
 rtl/dram_write_bridge.sv | 184 ++++++++++++++++++
 tb/tb_dram_write_bridge.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_write_bridge.sv
// dram_write_bridge: buffers packer write beats in a small FIFO and issues them
// to the DDR controller user interface as single-beat write bursts. The command
// and write-data handshakes complete independently, and the entry is popped once
// both of them have been accepted.
module dram_write_bridge #(
   parameter int unsigned MEM_IF_WIDTH = 128,
   parameter int unsigned ADX_WIDTH    = 27,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned LEVEL_WIDTH  = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      write_req,
   input  logic [MEM_IF_WIDTH-1:0]   dram_data,
   input  logic [ADX_WIDTH-1:0]      dram_adx,
   output logic                      write_allowed,
   input  logic                      init_calib_complete,
   output logic [ADX_WIDTH-1:0]      app_addr,
   output logic [2:0]                app_cmd,
   output logic                      app_en,
   input  logic                      app_rdy,
   output logic [MEM_IF_WIDTH-1:0]   app_wdf_data,
   output logic                      app_wdf_wren,
   output logic                      app_wdf_end,
   output logic [MEM_IF_WIDTH/8-1:0] app_wdf_mask,
   input  logic                      app_wdf_rdy,
   output logic [LEVEL_WIDTH-1:0]    fifo_level,
   output logic                      overflow,
   output logic                      idle
);

   localparam int unsigned PTR_WIDTH   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned ENTRY_WIDTH = ADX_WIDTH + MEM_IF_WIDTH;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_t;

   state_t                  state;
   state_t                  state_next;

   logic [ENTRY_WIDTH-1:0]  mem [FIFO_DEPTH];
   logic [ENTRY_WIDTH-1:0]  head;
   logic [PTR_WIDTH-1:0]    wr_ptr;
   logic [PTR_WIDTH-1:0]    rd_ptr;
   logic [LEVEL_WIDTH-1:0]  level;

   logic                    full;
   logic                    empty;
   logic                    push;
   logic                    pop;
   logic                    entries_left;

   logic                    cmd_done;
   logic                    data_done;
   logic                    cmd_hit;
   logic                    dat_hit;

   // FIFO occupancy flags and the packer-side accept decision
   assign full          = (level == LEVEL_WIDTH'(FIFO_DEPTH));
   assign empty         = (level == '0);
   assign write_allowed = init_calib_complete & ~full;
   assign push          = write_req & write_allowed;

   // Entries still queued after a pop, including one arriving this cycle
   assign entries_left  = (level > LEVEL_WIDTH'(1)) | push;

   // Head entry drives both the command address and the write data
   assign head          = mem[rd_ptr];
   assign app_addr      = head[ENTRY_WIDTH-1 -: ADX_WIDTH];
   assign app_wdf_data  = head[MEM_IF_WIDTH-1:0];

   // Fixed controller fields: write command, single-beat bursts, no byte masking
   assign app_cmd       = 3'b000;
   assign app_wdf_end   = app_wdf_wren;
   assign app_wdf_mask  = '0;

   assign fifo_level    = level;
   assign idle          = empty & (state == IDLE);

   // FIFO storage; contents need no reset since level/pointers qualify them
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {dram_adx, dram_data};
      end
   end

   // Write/read pointers and occupancy count
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_WIDTH'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_WIDTH'(1);
         end
         if (push && !pop) begin
            level <= level + LEVEL_WIDTH'(1);
         end else if (pop && !push) begin
            level <= level - LEVEL_WIDTH'(1);
         end
      end
   end

   // Sticky flag for write requests dropped because the bridge could not accept
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (write_req && !write_allowed) begin
         overflow <= 1'b1;
      end
   end

   // Per-entry handshake completion; both flags clear together when the entry pops
   always_ff @(posedge clk) begin
      if (reset) begin
         cmd_done  <= 1'b0;
         data_done <= 1'b0;
      end else if (pop) begin
         cmd_done  <= 1'b0;
         data_done <= 1'b0;
      end else begin
         if (cmd_hit) begin
            cmd_done <= 1'b1;
         end
         if (dat_hit) begin
            data_done <= 1'b1;
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM next state, strobes and pop decision
   always_comb begin
      state_next   = state;
      app_en       = 1'b0;
      app_wdf_wren = 1'b0;
      cmd_hit      = 1'b0;
      dat_hit      = 1'b0;
      pop          = 1'b0;

      case (state)
         IDLE: begin
            if (!empty && init_calib_complete) begin
               state_next = ISSUE;
            end
         end

         ISSUE: begin
            app_en       = ~cmd_done;
            app_wdf_wren = ~data_done;
            cmd_hit      = ~cmd_done & app_rdy;
            dat_hit      = ~data_done & app_wdf_rdy;
            pop          = (cmd_done | cmd_hit) & (data_done | dat_hit);
            // Calibration loss lets the current entry finish, then parks in IDLE
            if (pop) begin
               if (entries_left && init_calib_complete) begin
                  state_next = ISSUE;
               end else begin
                  state_next = IDLE;
               end
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_dram_write_bridge.sv
// Self-checking bench for dram_write_bridge: scoreboard queues hold expected
// addresses and data in issue order and are consumed on each controller handshake.
module tb_dram_write_bridge;

   localparam int unsigned MW = 128;
   localparam int unsigned AW = 27;
   localparam int unsigned LW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          write_req;
   logic [MW-1:0] dram_data;
   logic [AW-1:0] dram_adx;
   logic          write_allowed;
   logic          init_calib_complete;
   logic [AW-1:0] app_addr;
   logic [2:0]    app_cmd;
   logic          app_en;
   logic          app_rdy;
   logic [MW-1:0] app_wdf_data;
   logic          app_wdf_wren;
   logic          app_wdf_end;
   logic [MW/8-1:0] app_wdf_mask;
   logic          app_wdf_rdy;
   logic [LW-1:0] fifo_level;
   logic          overflow;
   logic          idle;

   int total = 0;
   int bad   = 0;
   int en_cnt   = 0;
   int wren_cnt = 0;
   int cmd_cnt  = 0;

   logic [AW-1:0] exp_adx_q [$];
   logic [MW-1:0] exp_dat_q [$];

   dram_write_bridge #(
      .MEM_IF_WIDTH (MW),
      .ADX_WIDTH    (AW),
      .FIFO_DEPTH   (4),
      .LEVEL_WIDTH  (LW)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .write_req           (write_req),
      .dram_data           (dram_data),
      .dram_adx            (dram_adx),
      .write_allowed       (write_allowed),
      .init_calib_complete (init_calib_complete),
      .app_addr            (app_addr),
      .app_cmd             (app_cmd),
      .app_en              (app_en),
      .app_rdy             (app_rdy),
      .app_wdf_data        (app_wdf_data),
      .app_wdf_wren        (app_wdf_wren),
      .app_wdf_end         (app_wdf_end),
      .app_wdf_mask        (app_wdf_mask),
      .app_wdf_rdy         (app_wdf_rdy),
      .fifo_level          (fifo_level),
      .overflow            (overflow),
      .idle                (idle)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one write_req cycle; exp_acc is the bench's own prediction of acceptance
   task automatic do_write(input logic [AW-1:0] adx, input logic [MW-1:0] data, input logic exp_acc);
      write_req = 1'b1;
      dram_adx  = adx;
      dram_data = data;
      check("write_allowed", MW'(write_allowed), MW'(exp_acc));
      if (exp_acc) begin
         exp_adx_q.push_back(adx);
         exp_dat_q.push_back(data);
      end
      step();
      write_req = 1'b0;
   endtask

   function automatic logic [MW-1:0] rnd_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Handshake monitor: scoreboard compare on every accepted command / data beat
   always @(negedge clk) begin
      if (!reset) begin
         if (app_en) en_cnt++;
         if (app_wdf_wren) wren_cnt++;
         check("wdf_end", MW'(app_wdf_end), MW'(app_wdf_wren));
         if (app_en && app_rdy) begin
            cmd_cnt++;
            check("cmd_expected", MW'(exp_adx_q.size() != 0), MW'(1'b1));
            if (exp_adx_q.size() != 0) begin
               check("cmd_addr", MW'(app_addr), MW'(exp_adx_q.pop_front()));
               check("cmd_code", MW'(app_cmd), MW'(3'b000));
            end
         end
         if (app_wdf_wren && app_wdf_rdy) begin
            check("dat_expected", MW'(exp_dat_q.size() != 0), MW'(1'b1));
            if (exp_dat_q.size() != 0) begin
               check("wdf_data", app_wdf_data, exp_dat_q.pop_front());
               check("wdf_mask", MW'(app_wdf_mask), MW'(0));
            end
         end
      end
   end

   initial begin
      logic [MW-1:0] d0;
      logic [AW-1:0] adx [8];
      int            e0;
      int            w0;
      int            c0;

      reset               = 1'b1;
      init_calib_complete = 1'b0;
      app_rdy             = 1'b0;
      app_wdf_rdy         = 1'b0;
      write_req           = 1'b0;
      dram_adx            = '0;
      dram_data           = '0;

      // Reset state
      repeat (2) step();
      check("rst_app_en", MW'(app_en), MW'(0));
      check("rst_wren", MW'(app_wdf_wren), MW'(0));
      check("rst_wdf_end", MW'(app_wdf_end), MW'(0));
      check("rst_level", MW'(fifo_level), MW'(0));
      check("rst_overflow", MW'(overflow), MW'(0));
      check("rst_idle", MW'(idle), MW'(1));
      check("rst_wa_nocal", MW'(write_allowed), MW'(0));
      reset               = 1'b0;
      init_calib_complete = 1'b1;
      app_rdy             = 1'b1;
      app_wdf_rdy         = 1'b1;
      step();

      // Single write: strobes exactly one cycle, two cycles after the request
      e0 = en_cnt;
      d0 = {96'h0123_4567_89AB_CDEF_0011_2233, 32'hDEADBEEF};
      do_write(AW'(27'h0000008), d0, 1'b1);
      check("single_en_n1", MW'(app_en), MW'(0));
      step();
      check("single_en", MW'(app_en), MW'(1));
      check("single_wren", MW'(app_wdf_wren), MW'(1));
      check("single_end", MW'(app_wdf_end), MW'(1));
      check("single_addr", MW'(app_addr), MW'(27'h8));
      check("single_data", app_wdf_data, d0);
      step();
      check("single_en_off", MW'(app_en), MW'(0));
      check("single_level", MW'(fifo_level), MW'(0));
      check("single_idle", MW'(idle), MW'(1));
      step();
      check("single_en_cycles", MW'(en_cnt - e0), MW'(1));

      // Back-to-back streaming: one command per cycle, in order
      for (int i = 0; i < 8; i++) adx[i] = AW'(32'h100 + 32'(i) * 32'h10);
      for (int i = 0; i < 8; i++) begin
         do_write(adx[i], rnd_data(), 1'b1);
         if (i >= 1) begin
            check("stream_en", MW'(app_en), MW'(1));
            check("stream_addr", MW'(app_addr), MW'(adx[i-1]));
         end
      end
      check("stream_en_tail", MW'(app_en), MW'(1));
      step();
      check("stream_en_last", MW'(app_en), MW'(1));
      check("stream_addr_last", MW'(app_addr), MW'(adx[7]));
      step();
      check("stream_en_done", MW'(app_en), MW'(0));
      check("stream_overflow", MW'(overflow), MW'(0));
      check("stream_level", MW'(fifo_level), MW'(0));

      // Full FIFO and backpressure: fifth request is dropped and flagged
      app_rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         do_write(AW'(32'h2000 + 32'(i)), rnd_data(), (i < 4));
      end
      check("full_level", MW'(fifo_level), MW'(4));
      check("full_wa", MW'(write_allowed), MW'(0));
      check("full_overflow", MW'(overflow), MW'(1));
      c0 = cmd_cnt;
      app_rdy = 1'b1;
      repeat (8) step();
      check("full_drain_cnt", MW'(cmd_cnt - c0), MW'(4));
      check("full_drain_level", MW'(fifo_level), MW'(0));
      check("full_q_adx", MW'(exp_adx_q.size()), MW'(0));
      check("full_q_dat", MW'(exp_dat_q.size()), MW'(0));
      check("full_ovf_sticky", MW'(overflow), MW'(1));

      // Reset to clear the sticky overflow before the next group
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rst2_overflow", MW'(overflow), MW'(0));

      // Split handshake: data accepted first, command held off three cycles
      app_rdy     = 1'b0;
      app_wdf_rdy = 1'b1;
      e0 = en_cnt;
      w0 = wren_cnt;
      do_write(AW'(27'h3000), rnd_data(), 1'b1);
      repeat (3) step();
      check("splitA_level", MW'(fifo_level), MW'(1));
      step();
      app_rdy = 1'b1;
      step();
      check("splitA_level0", MW'(fifo_level), MW'(0));
      repeat (2) step();
      check("splitA_en_cycles", MW'(en_cnt - e0), MW'(4));
      check("splitA_wren_cycles", MW'(wren_cnt - w0), MW'(1));

      // Split handshake with roles swapped: command first, data held off
      app_rdy     = 1'b1;
      app_wdf_rdy = 1'b0;
      e0 = en_cnt;
      w0 = wren_cnt;
      do_write(AW'(27'h3100), rnd_data(), 1'b1);
      repeat (3) step();
      check("splitB_level", MW'(fifo_level), MW'(1));
      step();
      app_wdf_rdy = 1'b1;
      step();
      check("splitB_level0", MW'(fifo_level), MW'(0));
      repeat (2) step();
      check("splitB_en_cycles", MW'(en_cnt - e0), MW'(1));
      check("splitB_wren_cycles", MW'(wren_cnt - w0), MW'(4));

      // Calibration gating: requests refused and flagged while uncalibrated
      init_calib_complete = 1'b0;
      step();
      e0 = en_cnt;
      for (int i = 0; i < 3; i++) begin
         do_write(AW'($urandom), rnd_data(), 1'b0);
         step();
      end
      check("cal_overflow", MW'(overflow), MW'(1));
      check("cal_level", MW'(fifo_level), MW'(0));
      repeat (3) step();
      check("cal_no_en", MW'(en_cnt - e0), MW'(0));
      init_calib_complete = 1'b1;
      #1;
      check("cal_wa_restore", MW'(write_allowed), MW'(1));
      do_write(AW'(27'h4444), rnd_data(), 1'b1);
      repeat (4) step();
      check("cal_q_empty", MW'(exp_adx_q.size()), MW'(0));

      // Reset mid-stream: queued entries are discarded and never issued
      app_rdy     = 1'b0;
      app_wdf_rdy = 1'b0;
      for (int i = 0; i < 3; i++) do_write(AW'(32'h5000 + 32'(i)), rnd_data(), 1'b1);
      step();
      check("mid_level3", MW'(fifo_level), MW'(3));
      exp_adx_q.delete();
      exp_dat_q.delete();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mid_app_en", MW'(app_en), MW'(0));
      check("mid_level", MW'(fifo_level), MW'(0));
      check("mid_overflow", MW'(overflow), MW'(0));
      check("mid_idle", MW'(idle), MW'(1));
      app_rdy     = 1'b1;
      app_wdf_rdy = 1'b1;
      e0 = en_cnt;
      repeat (10) step();
      check("mid_no_stale", MW'(en_cnt - e0), MW'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
